pipe_serializer: RTL
====================

Name: pipe_serializer

Overview:
Valid/ready wide-to-narrow stream serializer. It accepts one wide beat of RATIO words and transmits it as a sequence of DWIDTH-bit words, least-significant word first. It sits at the transmit end of a pipeline stage chain, feeding narrow links or pipe skid buffers. It is fully registered on the output side and sustains 1 word/cycle with no bubbles between beats.

Parameters:
DWIDTH, 8, output word width in bits (>=1)
RATIO, 4, words per input beat; power of 2, >=2
LWIDTH, $clog2(RATIO), width of length field and word counter (derived, not overridable)

Ports:
clk  input  1  clock
rst  input  1  reset; one clock; reset is synchronous and active-high
i_data  input  DWIDTH*RATIO  wide input beat; word k = i_data[k*DWIDTH +: DWIDTH]
i_len  input  LWIDTH  number of valid words in the beat minus 1 (0 => 1 word, RATIO-1 => full)
i_valid  input  1  input beat valid
o_ready  output  1  input ready; a beat transfers when i_valid & o_ready
o_data  output  DWIDTH  output word
o_last  output  1  high on the final word of each input beat
o_valid  output  1  output word valid
i_ready  input  1  downstream ready; a word transfers when o_valid & i_ready

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; o_valid=0, o_last=0, o_data=0, shift register=0, word counter=0. o_ready=0 combinationally while rst=1. Reset mid-beat discards the remaining words; no partial output after reset.
- Internal state: shift register SR (DWIDTH*RATIO), remaining-word counter CNT (LWIDTH), state IDLE/SEND.
- Output handshake (AXI-style): once o_valid=1, o_data/o_last/o_valid hold stable until i_ready=1. o_valid never drops without a transfer.
- word_done = o_valid & i_ready.
- o_ready = ~rst & (state==IDLE | (word_done & o_last)). The combinational i_ready->o_ready path is intentional and allows back-to-back beats.
- IDLE: on i_valid & o_ready: o_data<=word0, o_valid<=1, o_last<=(i_len==0), SR<=i_data>>DWIDTH, CNT<=i_len, state<=SEND. Otherwise o_valid stays 0.
- SEND, word_done & ~o_last: o_data<=SR[DWIDTH-1:0], SR<=SR>>DWIDTH, CNT<=CNT-1, o_last<=(CNT==1).
- SEND, word_done & o_last: if i_valid, load the new beat exactly as in IDLE (no bubble, state stays SEND). Otherwise o_valid<=0, o_last<=0, state<=IDLE. o_data holds its last value.
- SEND, ~word_done: all registers hold. The input is stalled (o_ready=0).
- Latency: beat accepted at edge N, so word0 is visible after edge N; a beat of L+1 words occupies L+1 output transfers.
- Words above i_len are never emitted. Their content is don't-care.
- i_len, i_data and i_valid are sampled only at the transfer edge. Input changes while o_ready=0 are ignored.
- Throughput: with i_ready held high and i_valid high, o_valid is continuously 1; the input accepts one beat every (i_len+1) cycles.
- Fixed priority: rst > beat load > word advance.

Decomposition:
- Package pipe_pkg: state enum typedef (IDLE, SEND), and a function for word extraction/length compare, shared with future pipe_* blocks (deserializer).
- No sub-module needed. An optional downstream pipe skid buffer is instantiated by the integrator, not inside this block.

Test Plan:
- Reset/idle: hold rst 3 cycles, release with i_valid=0 -> o_valid=0, o_data=0, o_last=0; o_ready=0 during rst, 1 on the first cycle after.
- Full beat, DWIDTH=8, RATIO=4: i_data=32'hDDCCBBAA, i_len=3, i_ready=1 -> o_data AA,BB,CC,DD on 4 consecutive cycles; o_last only on DD; o_ready=1 again in the DD cycle.
- Short beats back-to-back: beat1 32'h44332211 with i_len=1, then beat2 32'h88776655 with i_len=0, i_valid held -> output 11,22(last),55(last) with no gap cycles; bytes 33/44/66/77/88 never appear.
- Backpressure: full beat with i_ready toggling 1,0,0,1,0,1,1 -> each word held stable across stall cycles; order and o_last preserved; o_ready stays 0 until the last word transfers.
- Reset mid-beat: assert rst after word BB of 32'hDDCCBBAA -> next cycle o_valid=0; after release, a new beat 32'h0000_00EE with i_len=0 emits only EE with o_last=1.
- Randomized soak plus scoreboard: random i_valid/i_ready/i_len over 10k beats -> the output word stream equals the concatenated valid words; exactly one o_last per beat.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and helpers for the pipe_* stream blocks.
package pipe_pkg;
  typedef enum logic {IDLE, SEND} state_t;
  function automatic logic cnt_is(input int unsigned cnt, input int unsigned v);
    return cnt == v;
  endfunction
  function automatic logic [31:0] word_at(input logic [1023:0] bus, input int unsigned k, input int unsigned w);
    return 32'(bus >> (k * w));
  endfunction
endpackage

// File: rtl/pipe_serializer.sv
// pipe_serializer: wide-to-narrow valid/ready serializer, LS word first, registered outputs.
module pipe_serializer
  import pipe_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int RATIO  = 4,
  localparam int LWIDTH = $clog2(RATIO)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DWIDTH*RATIO-1:0]  i_data,
  input  logic [LWIDTH-1:0]        i_len,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic [DWIDTH-1:0]        o_data,
  output logic                     o_last,
  output logic                     o_valid,
  input  logic                     i_ready
);
  localparam int WW = DWIDTH * RATIO;
  state_t state_q, state_d;
  logic [WW-1:0] sr_q, sr_d;
  logic [LWIDTH-1:0] cnt_q, cnt_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic last_q, last_d, valid_q, valid_d;
  logic word_done, load;
  assign word_done = valid_q & i_ready;
  // i_ready feeds o_ready combinationally so a new beat loads on the last word's transfer
  assign o_ready = ~rst & ((state_q == IDLE) | (word_done & last_q));
  assign load = i_valid & o_ready;
  assign o_data = data_q;
  assign o_last = last_q;
  assign o_valid = valid_q;
  always_comb begin
    state_d = state_q;
    sr_d = sr_q;
    cnt_d = cnt_q;
    data_d = data_q;
    last_d = last_q;
    valid_d = valid_q;
    if (load) begin
      data_d = i_data[DWIDTH-1:0];
      valid_d = 1'b1;
      last_d = cnt_is(32'(i_len), 0);
      sr_d = i_data >> DWIDTH;
      cnt_d = i_len;
      state_d = SEND;
    end else if (word_done & ~last_q) begin
      data_d = sr_q[DWIDTH-1:0];
      sr_d = sr_q >> DWIDTH;
      cnt_d = cnt_q - LWIDTH'(1);
      last_d = cnt_is(32'(cnt_q), 1);
    end else if (word_done) begin
      valid_d = 1'b0;
      last_d = 1'b0;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
      last_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      last_q <= last_d;
      valid_q <= valid_d;
    end
  end
endmodule
